// File: rtl/maxpool_pkg.sv
// Shared definitions for the windowed max-pooling sequencer: FSM encoding,
// default window capacity and the counter-width helper.
package maxpool_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int KMAX_DEFAULT = 16;

    // Bits needed to hold a count from 0 up to and including kmax.
    function automatic int count_width(input int kmax);
        return $clog2(kmax + 1);
    endfunction

endpackage

// File: rtl/maxpool_max_unit.sv
// Unsigned two-input maximum; ties resolve to input a so a new element
// equal to the running maximum replaces it.
module maxpool_max_unit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    assign y = (a >= b) ? a : b;

endmodule

// File: rtl/maxpool_window_seq.sv
// Streams win_size elements per window, emits the window maximum, and repeats
// for num_win windows; one bubble per window while the result is presented.
module maxpool_window_seq
    import maxpool_pkg::*;
#(
    parameter int N    = 8,
    parameter int KMAX = KMAX_DEFAULT,
    parameter int CW   = count_width(KMAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] win_size,
    input  logic [15:0]   num_win,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    localparam logic [CW-1:0] KMAX_C = CW'(KMAX);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    state_t        state_reg, state_next;
    logic [CW-1:0] elem_cnt_reg, elem_cnt_next;
    logic [15:0]   win_cnt_reg, win_cnt_next;
    logic [N-1:0]  acc_reg, acc_next;
    logic [CW-1:0] win_size_reg, win_size_next;
    logic [15:0]   num_win_reg, num_win_next;
    logic          cfg_err_reg, cfg_err_next;

    logic          cfg_ok;
    logic          beat;
    logic          last_beat;
    logic          last_win;
    logic [N-1:0]  max_y;

    maxpool_max_unit #(.N(N)) u_max (
        .a (in_data),
        .b (acc_reg),
        .y (max_y)
    );

    assign cfg_ok    = (win_size != '0) && (win_size <= KMAX_C) && (num_win != 16'd0);
    assign beat      = in_valid && (state_reg == ACCUM);
    assign last_beat = (elem_cnt_reg + ONE_C) == win_size_reg;
    assign last_win  = (win_cnt_reg + 16'd1) == num_win_reg;

    always_comb begin
        state_next    = state_reg;
        elem_cnt_next = elem_cnt_reg;
        win_cnt_next  = win_cnt_reg;
        acc_next      = acc_reg;
        win_size_next = win_size_reg;
        num_win_next  = num_win_reg;
        cfg_err_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        win_size_next = win_size;
                        num_win_next  = num_win;
                        elem_cnt_next = '0;
                        win_cnt_next  = '0;
                        acc_next      = '0;
                        state_next    = ACCUM;
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (beat) begin
                    // The first element seeds the window so nothing leaks from the previous one.
                    acc_next      = (elem_cnt_reg == '0) ? in_data : max_y;
                    elem_cnt_next = elem_cnt_reg + ONE_C;
                    if (last_beat) begin
                        state_next = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    win_cnt_next = win_cnt_reg + 16'd1;
                    if (last_win) begin
                        state_next = DONE;
                    end else begin
                        elem_cnt_next = '0;
                        state_next    = ACCUM;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            elem_cnt_reg <= '0;
            win_cnt_reg  <= '0;
            acc_reg      <= '0;
            win_size_reg <= '0;
            num_win_reg  <= '0;
            cfg_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            elem_cnt_reg <= elem_cnt_next;
            win_cnt_reg  <= win_cnt_next;
            acc_reg      <= acc_next;
            win_size_reg <= win_size_next;
            num_win_reg  <= num_win_next;
            cfg_err_reg  <= cfg_err_next;
        end
    end

    assign in_ready  = (state_reg == ACCUM);
    assign out_valid = (state_reg == EMIT);
    assign out_data  = acc_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_maxpool_window_seq.sv
// Scoreboard bench for maxpool_window_seq: directed windows, stalls, config
// errors, mid-job reset and randomised flow control against a max model.
module tb_maxpool_window_seq;

    localparam int N    = 8;
    localparam int KMAX = 16;
    localparam int CW   = $clog2(KMAX + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] win_size = '0;
    logic [15:0]   num_win = '0;
    logic          in_valid = 1'b0;
    logic [N-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [N-1:0]  out_data;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          cfg_err;

    int            tests_run = 0;
    int            tests_failed = 0;
    logic [N-1:0]  exp_q[$];
    logic [N-1:0]  cur_win[$];
    logic [N-1:0]  exp_v;
    logic [N-1:0]  data_prev;
    bit            hold_prev = 1'b0;
    bit            rand_ready_en = 1'b0;

    always #5 clk = ~clk;

    maxpool_window_seq #(.N(N), .KMAX(KMAX), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .win_size  (win_size),
        .num_win   (num_win),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pops on handshakes, stall stability, no input during EMIT.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check_val("hold_valid", out_valid, 1);
                check_val("hold_data", out_data, data_prev);
            end
            if (out_valid) check_val("in_ready_in_emit", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_result", exp_q.size(), 1);
                end else begin
                    exp_v = exp_q.pop_front();
                    $display("[TB] result %0d expected %0d", out_data, exp_v);
                    check_val("out_data", out_data, exp_v);
                end
            end
            hold_prev = out_valid && !out_ready;
            data_prev = out_data;
        end
    end

    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1;
            out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    function automatic logic [N-1:0] ref_max();
        logic [N-1:0] m;
        m = '0;
        foreach (cur_win[i]) if (cur_win[i] > m) m = cur_win[i];
        return m;
    endfunction

    task automatic start_job(input int ws, input int nw);
        start    = 1'b1;
        win_size = CW'(ws);
        num_win  = 16'(nw);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [N-1:0] d, input bit gaps);
        bit ok;
        ok = 1'b0;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("beat_accept", ok, 1);
    endtask

    // Sends cur_win as one window; the result must be valid one cycle after the last beat.
    task automatic run_window(input bit gaps);
        logic [N-1:0] m;
        m = ref_max();
        exp_q.push_back(m);
        foreach (cur_win[i]) send_beat(cur_win[i], gaps);
        @(negedge clk);
        check_val("latency_valid", out_valid, 1);
        check_val("latency_data", out_data, m);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        check_val("done_seen", seen, 1);
        @(negedge clk);
        check_val("done_one_cycle", done, 0);
        check_val("idle_busy", busy, 0);
        check_val("sb_drained", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int bad_ws[3];
        int bad_nw[3];
        int ws;
        int nw;
        int vals[4];
        bad_ws = '{0, KMAX + 1, 4};
        bad_nw = '{1, 1, 0};
        vals   = '{17, 0, 255, 128};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_cfg_err", cfg_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single window of four.
        start_job(4, 1);
        check_val("busy_after_start", busy, 1);
        cur_win = {8'd3, 8'd9, 8'd2, 8'd7};
        run_window(1'b0);
        wait_done();

        // Three windows, no carry between them.
        start_job(3, 3);
        cur_win = {8'd0, 8'd0, 8'd0};
        run_window(1'b0);
        cur_win = {8'd255, 8'd1, 8'd255};
        run_window(1'b0);
        cur_win = {8'd5, 8'd6, 8'd4};
        run_window(1'b0);
        wait_done();

        // Stalled output; a start during the job must be ignored.
        out_ready = 1'b0;
        start_job(2, 1);
        cur_win = {8'd10, 8'd20};
        run_window(1'b0);
        start = 1'b1; win_size = CW'(1); num_win = 16'd1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            check_val("stall_valid", out_valid, 1);
            check_val("stall_data", out_data, 20);
            check_val("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        wait_done();

        // Window of one: pass-through.
        start_job(1, 4);
        foreach (vals[i]) begin
            cur_win = {8'(vals[i])};
            run_window(1'b0);
        end
        wait_done();

        // Largest legal window, descending data.
        start_job(KMAX, 1);
        cur_win.delete();
        for (int i = 0; i < KMAX; i++) cur_win.push_back(8'(200 - i));
        run_window(1'b0);
        wait_done();

        // Illegal configurations.
        foreach (bad_ws[i]) begin
            start_job(bad_ws[i], bad_nw[i]);
            @(negedge clk);
            check_val("cfg_err_pulse", cfg_err, 1);
            check_val("cfg_err_busy", busy, 0);
            @(negedge clk);
            check_val("cfg_err_clear", cfg_err, 0);
            check_val("cfg_err_idle", busy, 0);
            @(posedge clk); #1;
        end

        // Reset mid-window, then a clean job.
        start_job(4, 1);
        send_beat(8'd50, 1'b0);
        send_beat(8'd60, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_busy", busy, 0);
        check_val("abort_in_ready", in_ready, 0);
        check_val("abort_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        start_job(4, 1);
        cur_win = {8'd1, 8'd2, 8'd3, 8'd4};
        run_window(1'b0);
        wait_done();

        // Random sizes, data, input gaps and output backpressure.
        rand_ready_en = 1'b1;
        for (int j = 0; j < 8; j++) begin
            ws = $urandom_range(1, KMAX);
            nw = $urandom_range(1, 4);
            start_job(ws, nw);
            for (int w = 0; w < nw; w++) begin
                cur_win.delete();
                for (int e = 0; e < ws; e++) cur_win.push_back(8'($urandom_range(0, 255)));
                run_window(1'b1);
            end
            wait_done();
        end
        rand_ready_en = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/maxpool_window_seq.md
MAXPOOL_WINDOW_SEQ -- requirements
Module: maxpool_window_seq

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the element width in bits (unsigned).
REQ-002 The block SHALL have parameter KMAX, default 16, giving the maximum window size in elements.
REQ-003 The block SHALL have parameter CW, default $clog2(KMAX+1), giving the window-size field width.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port start, input, 1 bit: begins a pooling job when sampled high in IDLE.
REQ-007 The block SHALL have port win_size, input, CW bits: elements per window, latched at start.
REQ-008 The block SHALL have port num_win, input, 16 bits: windows per job, latched at start.
REQ-009 The block SHALL have ports in_valid (input, 1), in_data (input, N) and in_ready (output, 1): the element stream.
REQ-010 The block SHALL have ports out_valid (output, 1), out_data (output, N) and out_ready (input, 1): the result stream.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: a one-cycle pulse after the last result handshake.
REQ-013 The block SHALL have port cfg_err, output, 1 bit: a one-cycle pulse when start is rejected.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, ACCUM, EMIT and DONE.
REQ-015 In IDLE, start with 1<=win_size<=KMAX and num_win>=1 SHALL latch both values, clear the element and window counters, and enter ACCUM.
REQ-016 In IDLE, start with an illegal win_size or num_win SHALL pulse cfg_err for one cycle and remain in IDLE.
REQ-017 A start asserted outside IDLE SHALL be ignored.
REQ-018 in_ready SHALL be 1 only in ACCUM; a beat is accepted when in_valid and in_ready are both 1.
REQ-019 The first accepted beat of a window SHALL load the accumulator directly; each later beat SHALL replace the accumulator when in_data >= acc (unsigned compare).
REQ-020 The element counter SHALL increment per accepted beat; the beat making count==win_size SHALL move the FSM to EMIT.
REQ-021 out_valid SHALL be 1 only in EMIT, rising the cycle after the last accepted beat, so result latency is 1 cycle.
REQ-022 out_data SHALL equal the accumulator and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 On an EMIT handshake, the window counter SHALL increment; if windows remain, the FSM SHALL return to ACCUM with the element counter cleared.
REQ-024 On the EMIT handshake of the last window (window count reaches num_win), the FSM SHALL enter DONE.
REQ-025 DONE SHALL assert done for exactly one cycle and then return unconditionally to IDLE.
REQ-026 Throughput SHALL be win_size+1 cycles per window minimum, i.e. one bubble per window.
REQ-027 Each window SHALL be independent: accumulator state SHALL never carry across windows.

Reset
REQ-028 While rst=1, the FSM SHALL be in IDLE.
REQ-029 While rst=1, the accumulator and all counters SHALL be 0.
REQ-030 While rst=1, in_ready, out_valid, out_data, busy, done and cfg_err SHALL all be 0.
REQ-031 Reset asserted mid-job SHALL abort the job and discard any partial window; no result or done SHALL be produced for it.

Structure
REQ-032 Package maxpool_pkg SHALL hold the FSM state enum, the KMAX default and the count-width function.
REQ-033 The compare/select datapath SHALL be a single sub-module, maxpool_max_unit (A>=B selects A), instantiated once.

Verification
REQ-034 Bench SHALL cover: win_size=4, num_win=1, data 3,9,2,7 -> out_data=9 one cycle after the 4th beat, then done pulse.
REQ-035 Bench SHALL cover: win_size=3, num_win=3, data {0,0,0},{255,1,255},{5,6,4} -> outputs 0, 255, 6, and no carry between windows.
REQ-036 Bench SHALL cover: out_ready held low for 5 cycles in EMIT -> out_valid and out_data stable, in_ready=0 throughout.
REQ-037 Bench SHALL cover: win_size=1 -> each input value passes through to out_data; win_size=0 or KMAX+1 -> cfg_err pulse and busy stays 0.
REQ-038 Bench SHALL cover: rst pulsed after 2 of 4 beats, then a new job with data 1,2,3,4 -> out_data=4, with no stale result emitted.
REQ-039 Bench SHALL cover: random in_valid gaps and random out_ready with a scoreboard comparing against a reference max model.
